dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive DMA-losing cycles before the DMA port is forced a grant; legal range 1..15.
REQ-002 Parameter DEPTH_W, default 10: word-index width; the memory holds 2^DEPTH_W 32-bit words.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 pipe_req  in  1  MEM-stage access request, level, held while pipe_stall=1.
REQ-006 pipe_we  in  1  1=store word (SW), 0=load word (LW).
REQ-007 pipe_addr  in  32  byte address from the ALU output.
REQ-008 pipe_wdata  in  32  store data from the forwarding path.
REQ-009 pipe_stall  out  1  combinational; 1 = pipe request not serviced this cycle, the pipeline holds.
REQ-010 pipe_rdata  out  32  load data; valid when pipe_rvalid=1.
REQ-011 pipe_rvalid  out  1  one-cycle pulse, cycle after a granted pipe load.
REQ-012 dma_req, dma_we, dma_addr[32], dma_wdata[32]  in  debug/loader port; same meaning as the pipe_* inputs.
REQ-013 dma_gnt  out  1  combinational; 1 = DMA request accepted this cycle.
REQ-014 dma_rdata  out  32 / dma_rvalid  out  1  as for pipe_rdata/pipe_rvalid.
REQ-015 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-016 mem_idx  out  DEPTH_W  word index = addr[DEPTH_W+1:2]; mem_wdata  out  32.
REQ-017 mem_rdata  in  32  synchronous-read memory output, valid one cycle after mem_en with mem_we=0.
REQ-018 addr_err  out  1  sticky error flag.

Function
REQ-019 Exactly one requester is granted per cycle; a grant asserts mem_en for that cycle with the owner's we, index and wdata.
REQ-020 Default priority is the pipe: pipe_req=1 grants the pipe and asserts dma_gnt=0.
REQ-021 starve_cnt (4 bits) increments, saturating at STARVE_LIMIT, each cycle dma_req=1 and dma_gnt=0; it clears to 0 on a DMA grant or when dma_req=0.
REQ-022 If starve_cnt==STARVE_LIMIT and dma_req=1, the DMA is granted and pipe_stall=pipe_req for that cycle, regardless of pipe_req.
REQ-023 If pipe_req=0 and dma_req=1, the DMA is granted immediately.
REQ-024 The read-return FSM has states IDLE, RD_PIPE and RD_DMA. A granted load moves to RD_PIPE or RD_DMA; any other cycle moves to IDLE.
REQ-025 In RD_PIPE: pipe_rvalid=1 and pipe_rdata=mem_rdata. In RD_DMA: dma_rvalid=1 and dma_rdata=mem_rdata. Load latency is exactly 1 cycle after the grant.
REQ-026 rdata outputs hold their last value when rvalid=0.
REQ-027 Stores complete in the grant cycle; there is no rvalid for a store.
REQ-028 A request is illegal if addr[1:0]!=0 or addr[31:DEPTH_W+2]!=0. An illegal request is still granted (handshake completes) but mem_en=0; addr_err is set; a load returns rvalid with rdata=0.
REQ-029 addr_err clears only on reset.
REQ-030 Back-to-back grants are allowed every cycle; the return FSM transitions through RD_* states without passing through IDLE.
REQ-031 Reset mid-load: the pending rvalid is dropped and does not appear after rst_n rises.

Reset
REQ-032 With rst_n=0 the block drives: FSM=IDLE, starve_cnt=0, addr_err=0, pipe_rvalid=dma_rvalid=0, pipe_rdata=dma_rdata=0, mem_en=mem_we=0.
REQ-033 pipe_stall=0 and dma_gnt=0 during reset.
REQ-034 The first grant is possible in the first cycle after rst_n deasserts.

Verification
REQ-035 Pipe LW to addr 0x14, mem holds 5 at idx 5 -> mem_idx=5 in the grant cycle; pipe_rvalid=1 with pipe_rdata=5 the next cycle; pipe_stall=0.
REQ-036 Both requesters held continuously with STARVE_LIMIT=4 -> pipe granted 4 cycles, DMA granted on the 5th with pipe_stall=1, and the pattern repeats with a period of 5.
REQ-037 DMA SW 0xA5 to 0x20 while pipe_req=0 -> dma_gnt=1, mem_we=1, mem_idx=8, mem_wdata=0xA5 in the same cycle.
REQ-038 Pipe LW to 0x13 -> mem_en=0; addr_err=1 and stays 1; pipe_rvalid=1 with pipe_rdata=0 the next cycle.
REQ-039 Granted DMA load, then rst_n=0 before the next edge -> dma_rvalid is never asserted; all outputs take their reset values.
REQ-040 Alternating pipe LW / DMA LW every cycle -> rvalid pulses alternate between the ports with correct data and no gaps.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: pipe/DMA data-memory arbiter with starvation guard, address checking and one-cycle read return.
// Ports: clk/rst_n; pipe_* (MEM-stage request, stall, load return); dma_* (loader request, grant, load return);
// mem_* (synchronous memory strobe, write enable, word index, write data, read data); addr_err (sticky).
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DEPTH_W      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pipe_req,
  input  logic               pipe_we,
  input  logic [31:0]        pipe_addr,
  input  logic [31:0]        pipe_wdata,
  output logic               pipe_stall,
  output logic [31:0]        pipe_rdata,
  output logic               pipe_rvalid,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [31:0]        dma_addr,
  input  logic [31:0]        dma_wdata,
  output logic               dma_gnt,
  output logic [31:0]        dma_rdata,
  output logic               dma_rvalid,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DEPTH_W-1:0] mem_idx,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               addr_err
);
  typedef enum logic [1:0] {IDLE, RD_PIPE, RD_DMA} state_t;
  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        addr_err_q, addr_err_d;
  logic        rd_bad_q, rd_bad_d;
  logic [31:0] pipe_rdata_q, pipe_rdata_d, dma_rdata_q, dma_rdata_d;
  logic        dma_win, pipe_win, gnt_any, own_we, own_ok;
  logic [31:0] own_addr, own_wdata, ret_data;
  always_comb begin
    dma_win      = rst_n && dma_req && (!pipe_req || starve_q == 4'(STARVE_LIMIT));
    pipe_win     = rst_n && pipe_req && !dma_win;
    gnt_any      = dma_win || pipe_win;
    own_we       = dma_win ? dma_we : pipe_we;
    own_addr     = dma_win ? dma_addr : pipe_addr;
    own_wdata    = dma_win ? dma_wdata : pipe_wdata;
    own_ok       = own_addr[1:0] == 2'b00 && own_addr[31:DEPTH_W+2] == '0;
    pipe_stall   = rst_n && pipe_req && !pipe_win;
    dma_gnt      = dma_win;
    // an illegal address still completes the handshake but never touches memory
    mem_en       = gnt_any && own_ok;
    mem_we       = mem_en && own_we;
    mem_idx      = own_addr[DEPTH_W+1:2];
    mem_wdata    = own_wdata;
    ret_data     = rd_bad_q ? '0 : mem_rdata;
    pipe_rvalid  = state_q == RD_PIPE;
    dma_rvalid   = state_q == RD_DMA;
    pipe_rdata   = pipe_rvalid ? ret_data : pipe_rdata_q;
    dma_rdata    = dma_rvalid ? ret_data : dma_rdata_q;
    pipe_rdata_d = pipe_rdata;
    dma_rdata_d  = dma_rdata;
    addr_err     = addr_err_q;
    state_d      = (!gnt_any || own_we) ? IDLE : dma_win ? RD_DMA : RD_PIPE;
    rd_bad_d     = !own_ok;
    addr_err_d   = addr_err_q || (gnt_any && !own_ok);
    starve_d     = (!dma_req || dma_win) ? 4'd0 :
                   (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      addr_err_q   <= 1'b0;
      rd_bad_q     <= 1'b0;
      pipe_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      addr_err_q   <= addr_err_d;
      rd_bad_q     <= rd_bad_d;
      pipe_rdata_q <= pipe_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end
endmodule
